// File: rtl/hazard_trap_sequencer_pkg.sv
// rtl/hazard_trap_sequencer_pkg.sv - shared types and cause codes for the hazard/trap sequencer
package hazard_trap_sequencer_pkg;

  typedef struct packed {
    logic stall;
    logic flush;
  } control_t;

  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam int CAUSE_INSTR_MISALIGN = 0;
  localparam int CAUSE_ILLEGAL        = 2;
  localparam int CAUSE_BREAKPOINT     = 3;
  localparam int CAUSE_LOAD_MISALIGN  = 4;
  localparam int CAUSE_STORE_MISALIGN = 6;
  localparam int CAUSE_ECALL_M        = 11;

endpackage

// File: rtl/hazard_oldest_pick.sv
// rtl/hazard_oldest_pick.sv - priority encoder returning the oldest (highest index) valid exception
module hazard_oldest_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [N-1:0]  exc_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Ascending scan so the last hit, i.e. the oldest register, wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i] && exc_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/hazard_trap_sequencer.sv
// rtl/hazard_trap_sequencer.sv - stall/flush generation, oldest-first trap acceptance and settle FSM
module hazard_trap_sequencer
  import hazard_trap_sequencer_pkg::*;
#(
  parameter int NUM_REGS      = 4,
  parameter int REG_W         = 5,
  parameter int CAUSE_W       = 4,
  parameter int LOAD_LATENCY  = 1,
  parameter int BRANCH_REG    = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REGS-1:0]           reg_valid,
  input  logic [NUM_REGS-1:0]           reg_exc,
  input  logic [NUM_REGS*CAUSE_W-1:0]   reg_cause,
  input  logic [NUM_REGS*REG_W-1:0]     reg_dest,
  input  logic [NUM_REGS-1:0]           reg_is_load,
  input  logic [REG_W-1:0]              dec_rs1,
  input  logic [REG_W-1:0]              dec_rs2,
  input  logic                          dec_illegal,
  input  logic                          branch_taken,
  input  logic                          mret,
  input  logic                          stall_ext,
  output logic [NUM_REGS-1:0]           stall,
  output logic [NUM_REGS-1:0]           flush,
  output logic                          trap_take,
  output logic [CAUSE_W-1:0]            trap_cause,
  output logic [$clog2(NUM_REGS)-1:0]   trap_reg,
  output logic                          settling,
  output logic [CNT_W-1:0]              load_use_cnt
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e                      state_q, state_d;
  logic [SW-1:0]               scnt_q, scnt_d;
  logic [CNT_W-1:0]            lu_cnt_q, lu_cnt_d;
  control_t [NUM_REGS-1:0]     ctrl;
  logic                        found;
  logic [IW-1:0]               pick_idx;
  logic                        take_c;
  logic [CAUSE_W-1:0]          cause_c;
  logic [IW-1:0]               treg_c;
  logic                        hazard;
  logic                        redirect;
  logic                        unused_inputs;

  // Only registers 1..LOAD_LATENCY are inspected; the rest of these buses is don't-care here.
  assign unused_inputs = ^{reg_dest, reg_is_load};

  hazard_oldest_pick #(.N(NUM_REGS), .IW(IW)) u_pick (
    .valid_i (reg_valid),
    .exc_i   (reg_exc),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    hazard = 1'b0;
    for (int j = 1; j <= LOAD_LATENCY; j++) begin
      if (reg_valid[j] && reg_is_load[j] && (reg_dest[j*REG_W +: REG_W] != '0) &&
          reg_valid[0] && !dec_illegal &&
          ((reg_dest[j*REG_W +: REG_W] == dec_rs1) || (reg_dest[j*REG_W +: REG_W] == dec_rs2)))
        hazard = 1'b1;
    end
  end

  // mret and branch produce the same flush; they are merged here.
  assign redirect = mret || branch_taken;

  always_comb begin
    ctrl     = '0;
    take_c   = 1'b0;
    cause_c  = '0;
    treg_c   = '0;
    state_d  = state_q;
    scnt_d   = scnt_q;
    lu_cnt_d = lu_cnt_q;
    case (state_q)
      RUN: begin
        if (!stall_ext && found) begin
          take_c  = 1'b1;
          cause_c = reg_cause[pick_idx*CAUSE_W +: CAUSE_W];
          treg_c  = pick_idx;
          for (int i = 0; i < NUM_REGS; i++)
            if (IW'(i) <= pick_idx) ctrl[i].flush = 1'b1;
          state_d = SETTLE;
          scnt_d  = SW'(SETTLE_CYCLES - 1);
        end else begin
          if (redirect)
            for (int i = 0; i <= BRANCH_REG; i++) ctrl[i].flush = 1'b1;
          if (stall_ext) begin
            for (int i = 0; i < NUM_REGS; i++) ctrl[i].stall = 1'b1;
          end else if (hazard && !redirect) begin
            ctrl[0].stall = 1'b1;
            ctrl[1].flush = 1'b1;
            if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        ctrl[0].stall = 1'b1;
        ctrl[1].flush = 1'b1;
        if (stall_ext)
          for (int i = 0; i < NUM_REGS; i++) ctrl[i].stall = 1'b1;
        if (scnt_q == '0) state_d = RUN;
        else              scnt_d  = scnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= RUN;
      scnt_q   <= '0;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Every output, combinational ones included, is held at zero while reset is low.
  always_comb begin
    stall = '0;
    flush = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      stall[i] = reset && ctrl[i].stall;
      flush[i] = reset && ctrl[i].flush;
    end
    trap_take    = reset && take_c;
    trap_cause   = reset ? cause_c : '0;
    trap_reg     = reset ? treg_c : '0;
    settling     = reset && (state_q == SETTLE);
    load_use_cnt = reset ? lu_cnt_q : '0;
  end

endmodule

// File: tb/tb_hazard_trap_sequencer.sv
// tb/tb_hazard_trap_sequencer.sv - directed scoreboard bench for hazard_trap_sequencer
module tb_hazard_trap_sequencer;

  logic        clock;
  logic        reset;
  logic [3:0]  reg_valid, reg_exc, reg_is_load;
  logic [15:0] reg_cause;
  logic [19:0] reg_dest;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        dec_illegal, branch_taken, mret, stall_ext;
  logic [3:0]  stall, flush;
  logic        trap_take;
  logic [3:0]  trap_cause;
  logic [1:0]  trap_reg;
  logic        settling;
  logic [3:0]  load_use_cnt;

  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
    logic       take;
    logic [3:0] cause;
    logic [1:0] treg;
    logic       settling;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;
  int    model_cnt = 0;

  hazard_trap_sequencer #(
    .NUM_REGS(4), .REG_W(5), .CAUSE_W(4), .LOAD_LATENCY(2),
    .BRANCH_REG(1), .SETTLE_CYCLES(2), .CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset), .reg_valid(reg_valid), .reg_exc(reg_exc),
    .reg_cause(reg_cause), .reg_dest(reg_dest), .reg_is_load(reg_is_load),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .mret(mret), .stall_ext(stall_ext),
    .stall(stall), .flush(flush), .trap_take(trap_take), .trap_cause(trap_cause),
    .trap_reg(trap_reg), .settling(settling), .load_use_cnt(load_use_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b1; reg_valid = '0; reg_exc = '0; reg_is_load = '0;
    reg_cause = '0; reg_dest = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_illegal = 1'b0; branch_taken = 1'b0; mret = 1'b0; stall_ext = 1'b0;
  endtask

  // Inputs already driven; push expectation, compare 1ns later, then advance to the next negedge.
  task automatic step(input string tag, input logic [3:0] st, input logic [3:0] fl,
                      input logic tk, input logic [3:0] cs, input logic [1:0] rg,
                      input logic se, input logic hz);
    exp_t e;
    exp_t p;
    string t;
    e.stall = st; e.flush = fl; e.take = tk; e.cause = cs; e.treg = rg;
    e.settling = se;
    e.cnt = (reset == 1'b0) ? 4'd0 : 4'(model_cnt);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    p = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".stall"},    16'(stall),        16'(p.stall));
    chk({t, ".flush"},    16'(flush),        16'(p.flush));
    chk({t, ".take"},     16'(trap_take),    16'(p.take));
    chk({t, ".cause"},    16'(trap_cause),   16'(p.cause));
    chk({t, ".treg"},     16'(trap_reg),     16'(p.treg));
    chk({t, ".settling"}, 16'(settling),     16'(p.settling));
    chk({t, ".cnt"},      16'(load_use_cnt), 16'(p.cnt));
    if (reset == 1'b0) model_cnt = 0;
    else if (hz && model_cnt != 15) model_cnt++;
    @(negedge clock);
  endtask

  task automatic load_use_setup();
    idle();
    reg_valid = 4'b0101; reg_is_load = 4'b0100;
    reg_dest[2*5 +: 5] = 5'd5; dec_rs2 = 5'd5;
  endtask

  initial begin
    idle();
    reset = 1'b0; reg_valid = '1; reg_exc = '1; branch_taken = 1'b1; stall_ext = 1'b1;
    step("reset_a", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    step("reset_b", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    idle();
    step("idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    // Two exceptions: the oldest (reg 3) wins.
    reg_valid = 4'b1111; reg_exc = 4'b1010;
    reg_cause[1*4 +: 4] = 4'd2; reg_cause[3*4 +: 4] = 4'd4;
    step("trap_prio", 4'b0000, 4'b1111, 1, 4'd4, 2'd3, 0, 0);
    step("settle1",   4'b0001, 4'b0010, 0, 0, 0, 1, 0);
    branch_taken = 1'b1;
    step("settle2",   4'b0001, 4'b0010, 0, 0, 0, 1, 0);
    idle();
    step("run_again", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    load_use_setup();
    step("lu_reg2", 4'b0001, 4'b0010, 0, 0, 0, 0, 1);
    load_use_setup(); reg_dest[2*5 +: 5] = 5'd0; dec_rs2 = 5'd0;
    step("lu_x0", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    load_use_setup(); dec_illegal = 1'b1;
    step("lu_illegal", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    idle(); reg_valid = 4'b0011; reg_is_load = 4'b0010;
    reg_dest[1*5 +: 5] = 5'd7; dec_rs1 = 5'd7;
    step("lu_reg1_rs1", 4'b0001, 4'b0010, 0, 0, 0, 0, 1);
    idle(); reg_valid = 4'b1001; reg_is_load = 4'b1000;
    reg_dest[3*5 +: 5] = 5'd5; dec_rs2 = 5'd5;
    step("lu_beyond_lat", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    load_use_setup(); branch_taken = 1'b1;
    step("lu_branch", 4'b0000, 4'b0011, 0, 0, 0, 0, 0);
    idle(); mret = 1'b1;
    step("mret", 4'b0000, 4'b0011, 0, 0, 0, 0, 0);

    // Exception held off by stall_ext, accepted on release.
    idle(); reg_valid = 4'b0100; reg_exc = 4'b0100; reg_cause[2*4 +: 4] = 4'd6; stall_ext = 1'b1;
    step("ext1", 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
    step("ext2", 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
    branch_taken = 1'b1;
    step("ext3_branch", 4'b1111, 4'b0011, 0, 0, 0, 0, 0);
    branch_taken = 1'b0; stall_ext = 1'b0;
    step("ext_release", 4'b0000, 4'b0111, 1, 4'd6, 2'd2, 0, 0);

    // Reset during SETTLE aborts it.
    idle(); reset = 1'b0;
    step("reset_settle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    idle();
    step("after_reset", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      load_use_setup();
      step($sformatf("sat%0d", k), 4'b0001, 4'b0010, 0, 0, 0, 0, 1);
    end
    idle();
    step("sat_hold", 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_trap_sequencer.md
Name: hazard_trap_sequencer

Overview:
- Parametrised pipeline hazard and trap controller for an N-stage in-order core.
- Produces per-pipeline-register stall and flush vectors.
- Resolves exceptions oldest-first; takes traps through a settle FSM; covers multi-cycle load-use with configurable load latency and external memory stalls.
- Sits beside the pipeline registers and the CSR/trap unit; replaces the fixed 4-register combinational hazard logic.

Parameters:
- NUM_REGS, 4, number of pipeline registers; index 0 = fetch/decode (youngest), NUM_REGS-1 = oldest.
- REG_W, 5, register address width.
- CAUSE_W, 4, exception cause width.
- LOAD_LATENCY, 1, load dest unavailable while load sits in registers 1..LOAD_LATENCY (1 ≤ LOAD_LATENCY ≤ NUM_REGS-1).
- BRANCH_REG, 1, branch/mret resolved in register BRANCH_REG; flush registers 0..BRANCH_REG.
- SETTLE_CYCLES, 2, cycles fetch is held after a trap (≥1).
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- reg_valid  in  NUM_REGS  valid bit per pipeline register
- reg_exc  in  NUM_REGS  exception flag per register
- reg_cause  in  NUM_REGS*CAUSE_W  cause per register, flattened, register i at [i*CAUSE_W +: CAUSE_W]
- reg_dest  in  NUM_REGS*REG_W  destination register per pipeline register
- reg_is_load  in  NUM_REGS  writeback-from-memory flag per register
- dec_rs1, dec_rs2  in  REG_W each  source addresses decoded combinationally from register 0
- dec_illegal  in  1  combinational decode illegal; suppresses load-use check
- branch_taken  in  1  redirect from BRANCH_REG
- mret  in  1  mret resolved at BRANCH_REG
- stall_ext  in  1  memory/bus busy
- stall  out  NUM_REGS  hold register i
- flush  out  NUM_REGS  clear valid of register i
- trap_take  out  1  one-cycle pulse, trap accepted
- trap_cause  out  CAUSE_W  cause of accepted trap
- trap_reg  out  $clog2(NUM_REGS)  index of the faulting register (EPC select)
- settling  out  1  FSM in SETTLE
- load_use_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to RUN; settle counter and load_use_cnt clear to 0.
  - While reset is low, all outputs are forced to 0, combinational ones included.
- Reset mid-SETTLE aborts the settle; no trap_take on the following cycle.
- FSM RUN:
  - Trap candidate = highest index i with reg_valid[i] && reg_exc[i], evaluated only when stall_ext==0.
  - When a candidate exists:
    - trap_take=1, trap_cause=cause[i], trap_reg=i.
    - flush[0..i]=1.
    - Next state SETTLE with counter=SETTLE_CYCLES-1.
  - Registers older than i are untouched.
  - Else if mret or branch_taken: flush[0..BRANCH_REG]=1. mret wins over branch; the effect is identical and the difference is only for coverage.
- FSM SETTLE:
  - stall[0]=1, flush[1]=1 every cycle.
  - reg_exc, branch_taken and mret are ignored.
  - Counter decrements; at 0, return to RUN next cycle. Total hold = SETTLE_CYCLES cycles after the trap cycle.
  - stall_ext does not pause the counter.
- Load-use (RUN only, no trap this cycle, stall_ext==0):
  - Hazard when some j in 1..LOAD_LATENCY satisfies all of: reg_valid[j], reg_is_load[j], dest[j]!=0, reg_valid[0], !dec_illegal, and dest[j]==dec_rs1 or dest[j]==dec_rs2 (that rs nonzero).
  - Response: stall[0]=1, flush[1]=1.
  - If branch/mret flush fires in the same cycle, the flush wins and stall[0] is suppressed, because the dependent instruction is dead.
  - load_use_cnt increments per hazard cycle and saturates at all-ones.
- stall_ext==1:
  - stall = all ones; no trap accepted (deferred; exception re-evaluated when released).
  - Branch/mret flush still asserted, as in the existing pipeline contract.
  - No load-use evaluation.
- Width rules:
  - trap_reg is zero when no trap.
  - trap_cause is zero when trap_take==0.
  - Cause is passed unmodified.

Decomposition:
- Shared package: control_t (stall, flush) reused per register; cause constants (CAUSE_INSTR_MISALIGN=0, ILLEGAL=2, BREAKPOINT=3, LOAD_MISALIGN=4, STORE_MISALIGN=6, ECALL_M=11); state enum {RUN, SETTLE}.
- One sub-module: hazard_oldest_pick, a parametrised priority encoder returning the oldest valid exception index plus a found flag.

Test Plan:
- Trap priority: reg_exc[1] (cause 2) and reg_exc[3] (cause 4) both valid, NUM_REGS=4, SETTLE_CYCLES=2 -> trap_take=1, trap_cause=4, trap_reg=3, flush=4'b1111; settling=1 for the next 2 cycles with stall[0]=1; reg_exc[1] is ignored during SETTLE.
- Load-use, LOAD_LATENCY=2: load x5 in reg 2, dec_rs2=5 -> stall=4'b0001, flush=4'b0010, load_use_cnt 0→1. Same setup with dest x0, or dec_illegal=1 -> no stall.
- Branch vs load-use: hazard plus branch_taken same cycle -> flush=4'b0011, stall[0]=0, counter unchanged.
- stall_ext with pending exception: reg_exc[2] held for 3 cycles of stall_ext=1 -> stall=4'b1111, trap_take=0; on release trap_take=1, trap_reg=2.
- Reset in SETTLE: trap taken, reset=0 for one cycle on the next edge -> all outputs 0, settling=0 afterwards, load_use_cnt=0.
- Counter saturation, CNT_W=4: 20 consecutive hazard cycles -> load_use_cnt holds at 15.
